multi_chn_disp_scan: RTL and testbench
======================================

Name: multi_chn_disp_scan

Overview:
Parametrised N-channel display-source multiplexer for the 7-segment display path. It selects one of N_CH data words, with matching per-digit point and LED-enable masks, and drives the display driver. Selection is either manual, via a Test select input, or automatic: a scan sequencer steps through the channels with a programmable dwell time. All outputs are registered, and the block sits between the data sources and the display driver.

Parameters:
N_CH, 8, number of input channels (2..16)
DATA_W, 32, width of each data word and of Disp_num
DIG, 8, digits per channel; width of each point/LE slice
SEL_W, 3, channel-select width; must satisfy 2**SEL_W >= N_CH
DWELL_W, 24, width of dwell counter/threshold

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
EN  input  1  global enable; 0 freezes all state and outputs
mode  input  1  0 = manual select, 1 = auto scan
Test  input  SEL_W  manual channel select
dwell  input  DWELL_W  auto-scan dwell: channel advances every dwell+1 cycles
hold  input  1  auto mode: pause scanning
data_in  input  N_CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W]
point_in  input  N_CH*DIG  channel k decimal-point mask at [k*DIG +: DIG]
LES  input  N_CH*DIG  channel k LED-enable mask at [k*DIG +: DIG]
Disp_num  output  DATA_W  registered selected data
point_out  output  DIG  registered selected point mask
LE_out  output  DIG  registered selected LE mask
ch_cur  output  SEL_W  currently displayed channel
ch_tick  output  1  one-cycle pulse when ch_cur changes

Behaviour:
- Reset, asynchronous: Disp_num, point_out, LE_out, ch_cur, ch_tick and the dwell counter all go to 0.
- Internal ch_next is combinational. On each enabled edge, ch_cur <= ch_next and the outputs load slice ch_next. Outputs therefore always match ch_cur, with 1-cycle latency from inputs.
- Channel data in the selected slice is sampled every enabled cycle, so live data changes appear 1 cycle later even without a channel change.
- EN=0:
  - ch_cur, the counter and all outputs hold their values.
  - ch_tick = 0.
  - EN overrides mode and hold.
- Manual mode (mode=0):
  - If Test < N_CH, ch_next = Test.
  - If Test >= N_CH, ch_next = ch_cur (select ignored).
  - The dwell counter is held at 0.
- Auto mode (mode=1, hold=0):
  - The counter increments each cycle.
  - When counter == dwell: ch_next = (ch_cur == N_CH-1) ? 0 : ch_cur+1, and the counter clears to 0.
  - dwell = 0 advances every cycle.
  - If dwell is reduced below the current count, the counter wraps to 0 at its maximum. No early advance occurs.
- Auto mode with hold=1:
  - Counter and ch_cur are frozen.
  - Outputs keep refreshing from the live data of ch_cur.
- Mode change manual->auto: scanning starts from the current ch_cur with counter 0. The first advance comes dwell+1 cycles after auto is entered.
- Mode change auto->manual: on the next edge, ch_cur = Test (if in range) and the counter clears.
- ch_tick: registered, 1 on the edge where ch_cur takes a value different from its previous value, else 0. It also fires on a manual select change.
- No combinational path exists from inputs to outputs.

Test Plan:
- Reset and manual select:
  - Stimulus: assert rst mid-run, then release with mode=0, Test=5, data_in channel 5 = 32'hDEADBEEF, point_in[5] = 8'h0F, LES[5] = 8'hF0.
  - Required: all outputs 0 during reset. One edge after release: Disp_num = DEADBEEF, point_out = 0F, LE_out = F0, ch_cur = 5, ch_tick = 1 for that cycle.
- Auto scan wrap:
  - Stimulus: mode=1, dwell=3, starting at ch_cur=6.
  - Required: ch_cur = 6 for 4 cycles, then 7 for 4 cycles, then 0. ch_tick pulses exactly once per step. Outputs track each channel's data.
- dwell=0 and hold:
  - Stimulus: dwell=0; hold=1 at ch_cur=2 for 10 cycles while channel 2 data changes to 32'h12345678.
  - Required: with dwell=0, ch_cur steps every cycle. During hold, ch_cur stays 2, Disp_num shows 12345678 one cycle after the change, and ch_tick stays 0.
- EN low:
  - Stimulus: drop EN for 5 cycles during auto scan while changing Test and data.
  - Required: all outputs and ch_cur frozen. After EN returns, the remaining dwell count resumes.
- Out-of-range select:
  - Stimulus: N_CH=6, SEL_W=3; manual Test=7 while ch_cur=3.
  - Required: ch_cur stays 3, no ch_tick.
  - Also run auto mode with the same parameters. Required: channel sequence 4, 5, 0 (wraps at N_CH-1).
- Mode switch:
  - Stimulus: auto mode at ch_cur=4; switch to manual with Test=1, then back to auto with dwell=2.
  - Required: ch_cur = 1 on the next edge. After re-entering auto, ch_cur = 2 exactly 3 cycles later.

Source files
------------

// File: rtl/multi_chn_disp_scan.sv
// rtl/multi_chn_disp_scan.sv - N-channel display-source multiplexer with auto-scan sequencer
//
// Selects one of N_CH channel slices (data word, decimal-point mask, LED-enable
// mask) and drives them, registered, to the 7-segment display driver. The
// channel comes from Test in manual mode or from a dwell-timed scan sequencer
// in auto mode.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   EN           global enable; low freezes all state and outputs
//   mode         0 = manual select via Test, 1 = auto scan
//   Test         manual channel select (out-of-range values are ignored)
//   dwell        auto scan advances every dwell+1 cycles
//   hold         auto mode pause
//   data_in      channel k word at [k*DATA_W +: DATA_W]
//   point_in     channel k point mask at [k*DIG +: DIG]
//   LES          channel k LED-enable mask at [k*DIG +: DIG]
//   Disp_num     registered selected data word
//   point_out    registered selected point mask
//   LE_out       registered selected LED-enable mask
//   ch_cur       currently displayed channel
//   ch_tick      one-cycle pulse on each ch_cur change

module multi_chn_disp_scan #(
   parameter int N_CH    = 8,
   parameter int DATA_W  = 32,
   parameter int DIG     = 8,
   parameter int SEL_W   = 3,
   parameter int DWELL_W = 24
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   EN,
   input  logic                   mode,
   input  logic [SEL_W-1:0]       Test,
   input  logic [DWELL_W-1:0]     dwell,
   input  logic                   hold,
   input  logic [N_CH*DATA_W-1:0] data_in,
   input  logic [N_CH*DIG-1:0]    point_in,
   input  logic [N_CH*DIG-1:0]    LES,
   output logic [DATA_W-1:0]      Disp_num,
   output logic [DIG-1:0]         point_out,
   output logic [DIG-1:0]         LE_out,
   output logic [SEL_W-1:0]       ch_cur,
   output logic                   ch_tick
);

   // One extra bit so the range check also works when N_CH == 2**SEL_W.
   localparam logic [SEL_W:0]   NCH_EXT = (SEL_W+1)'(N_CH);
   localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

   logic [SEL_W-1:0]   ch_q,    ch_d;
   logic [DWELL_W-1:0] cnt_q,   cnt_d;
   logic [DATA_W-1:0]  disp_q,  disp_d;
   logic [DIG-1:0]     point_q, point_d;
   logic [DIG-1:0]     le_q,    le_d;
   logic               tick_q,  tick_d;

   always_comb begin
      ch_d    = ch_q;
      cnt_d   = cnt_q;
      disp_d  = disp_q;
      point_d = point_q;
      le_d    = le_q;
      tick_d  = 1'b0;

      if (EN) begin
         if (!mode) begin
            cnt_d = '0;
            if ({1'b0, Test} < NCH_EXT) begin
               ch_d = Test;
            end
         end else if (!hold) begin
            // Equality only: if dwell drops below the count, the counter
            // runs on and wraps instead of forcing an early advance.
            if (cnt_q == dwell) begin
               cnt_d = '0;
               ch_d  = (ch_q == LAST_CH) ? '0 : ch_q + SEL_W'(1);
            end else begin
               cnt_d = cnt_q + DWELL_W'(1);
            end
         end

         // Reload from the live slice every enabled cycle so data changes
         // on the shown channel appear without a channel change.
         disp_d  = data_in[ch_d*DATA_W +: DATA_W];
         point_d = point_in[ch_d*DIG +: DIG];
         le_d    = LES[ch_d*DIG +: DIG];
         tick_d  = (ch_d != ch_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ch_q    <= '0;
         cnt_q   <= '0;
         disp_q  <= '0;
         point_q <= '0;
         le_q    <= '0;
         tick_q  <= 1'b0;
      end else begin
         ch_q    <= ch_d;
         cnt_q   <= cnt_d;
         disp_q  <= disp_d;
         point_q <= point_d;
         le_q    <= le_d;
         tick_q  <= tick_d;
      end
   end

   assign Disp_num  = disp_q;
   assign point_out = point_q;
   assign LE_out    = le_q;
   assign ch_cur    = ch_q;
   assign ch_tick   = tick_q;

endmodule

// File: tb/tb_multi_chn_disp_scan.sv
// tb/tb_multi_chn_disp_scan.sv - scoreboard testbench for multi_chn_disp_scan

module tb_multi_chn_disp_scan;

   typedef logic [51:0] vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          EN;
   logic          mode;
   logic [2:0]    Test;
   logic [23:0]   dwell;
   logic          hold;
   logic [255:0]  data_in;
   logic [63:0]   point_in;
   logic [63:0]   LES;

   logic [31:0]   disp8, disp6;
   logic [7:0]    pt8, pt6, le8, le6;
   logic [2:0]    ch8, ch6;
   logic          tk8, tk6;

   logic [31:0]   dat [8];
   logic [7:0]    pt  [8];
   logic [7:0]    le  [8];

   vec_t          sb8 [$];
   vec_t          sb6 [$];
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   always_comb begin
      data_in  = '0;
      point_in = '0;
      LES      = '0;
      for (int k = 0; k < 8; k++) begin
         data_in[k*32 +: 32] = dat[k];
         point_in[k*8 +: 8]  = pt[k];
         LES[k*8 +: 8]       = le[k];
      end
   end

   multi_chn_disp_scan #(.N_CH(8), .DATA_W(32), .DIG(8), .SEL_W(3), .DWELL_W(24)) dut8 (
      .clk(clk), .rst(rst), .EN(EN), .mode(mode), .Test(Test), .dwell(dwell), .hold(hold),
      .data_in(data_in), .point_in(point_in), .LES(LES),
      .Disp_num(disp8), .point_out(pt8), .LE_out(le8), .ch_cur(ch8), .ch_tick(tk8)
   );

   multi_chn_disp_scan #(.N_CH(6), .DATA_W(32), .DIG(8), .SEL_W(3), .DWELL_W(24)) dut6 (
      .clk(clk), .rst(rst), .EN(EN), .mode(mode), .Test(Test), .dwell(dwell), .hold(hold),
      .data_in(data_in[191:0]), .point_in(point_in[47:0]), .LES(LES[47:0]),
      .Disp_num(disp6), .point_out(pt6), .LE_out(le6), .ch_cur(ch6), .ch_tick(tk6)
   );

   function automatic vec_t exp_vec(int ch, bit tk);
      return {dat[ch], pt[ch], le[ch], 3'(ch), tk};
   endfunction

   function automatic vec_t obs8();
      return {disp8, pt8, le8, ch8, tk8};
   endfunction

   function automatic vec_t obs6();
      return {disp6, pt6, le6, ch6, tk6};
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      vec_t e;
      rst = 1'b1; EN = 1'b1; mode = 1'b0; Test = 3'd2; dwell = '0; hold = 1'b0;
      for (int k = 0; k < 8; k++) begin
         dat[k] = 32'hA000_0000 + 32'(k * 32'h0101_0101);
         pt[k]  = 8'(8'h10 + k);
         le[k]  = 8'(8'hE0 + k);
      end
      repeat (2) cycle();
      checks++;
      if (obs8() !== '0 || obs6() !== '0) begin
         errors++;
         $display("FAIL reset_initial got %h / %h exp 0", obs8(), obs6());
      end
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         sb8.push_back(exp_vec(2, i == 0));
         cycle();
         e = sb8.pop_front();
         checks++;
         if (obs8() !== e) begin
            errors++;
            $display("FAIL reset_release%0d got %h exp %h", i, obs8(), e);
         end
      end
      // assert mid-cycle: asynchronous clear must not wait for an edge
      #2 rst = 1'b1;
      #1;
      checks++;
      if (obs8() !== '0 || obs6() !== '0) begin
         errors++;
         $display("FAIL reset_async got %h / %h exp 0", obs8(), obs6());
      end
      Test = 3'd5; dat[5] = 32'hDEADBEEF; pt[5] = 8'h0F; le[5] = 8'hF0;
      cycle();
      checks++;
      if (obs8() !== '0) begin
         errors++;
         $display("FAIL reset_held got %h exp 0", obs8());
      end
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         sb8.push_back(exp_vec(5, i == 0));
         cycle();
         e = sb8.pop_front();
         checks++;
         if (obs8() !== e) begin
            errors++;
            $display("FAIL reset_manual5_%0d got %h exp %h", i, obs8(), e);
         end
      end
   endtask

   task automatic test_auto_wrap();
      vec_t e;
      Test = 3'd6;
      sb8.push_back(exp_vec(6, 1'b1));
      cycle();
      e = sb8.pop_front();
      checks++;
      if (obs8() !== e) begin
         errors++;
         $display("FAIL wrap_start got %h exp %h", obs8(), e);
      end
      mode = 1'b1; dwell = 24'd3;
      for (int i = 1; i <= 12; i++) begin
         sb8.push_back(exp_vec((6 + i / 4) % 8, (i % 4) == 0));
         cycle();
         e = sb8.pop_front();
         checks++;
         if (obs8() !== e) begin
            errors++;
            $display("FAIL wrap_cyc%0d got %h exp %h", i, obs8(), e);
         end
      end
   endtask

   task automatic test_dwell0_hold();
      vec_t e;
      dwell = 24'd0;
      for (int i = 1; i <= 9; i++) begin
         sb8.push_back(exp_vec((1 + i) % 8, 1'b1));
         cycle();
         e = sb8.pop_front();
         checks++;
         if (obs8() !== e) begin
            errors++;
            $display("FAIL dwell0_cyc%0d got %h exp %h", i, obs8(), e);
         end
      end
      hold = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         if (i == 4) dat[2] = 32'h12345678;
         sb8.push_back(exp_vec(2, 1'b0));
         cycle();
         e = sb8.pop_front();
         checks++;
         if (obs8() !== e) begin
            errors++;
            $display("FAIL hold_cyc%0d got %h exp %h", i, obs8(), e);
         end
      end
   endtask

   task automatic test_en_low();
      vec_t e;
      vec_t last;
      hold = 1'b0; dwell = 24'd3;
      last = '0;
      for (int i = 1; i <= 2; i++) begin
         sb8.push_back(exp_vec(2, 1'b0));
         cycle();
         e = sb8.pop_front();
         last = e;
         checks++;
         if (obs8() !== e) begin
            errors++;
            $display("FAIL en_pre%0d got %h exp %h", i, obs8(), e);
         end
      end
      EN = 1'b0; Test = 3'd6; dat[2] = 32'hCAFEF00D;
      for (int i = 1; i <= 5; i++) begin
         sb8.push_back({last[51:1], 1'b0});
         cycle();
         e = sb8.pop_front();
         checks++;
         if (obs8() !== e) begin
            errors++;
            $display("FAIL en_low%0d got %h exp %h", i, obs8(), e);
         end
      end
      EN = 1'b1;
      for (int i = 0; i < 2; i++) begin
         sb8.push_back(exp_vec(2 + i, i == 1));
         cycle();
         e = sb8.pop_front();
         checks++;
         if (obs8() !== e) begin
            errors++;
            $display("FAIL en_resume%0d got %h exp %h", i, obs8(), e);
         end
      end
   endtask

   task automatic test_out_of_range();
      vec_t e;
      mode = 1'b0; Test = 3'd3;
      cycle();
      sb6.push_back(exp_vec(3, 1'b0));
      cycle();
      e = sb6.pop_front();
      checks++;
      if (obs6() !== e) begin
         errors++;
         $display("FAIL oor_set3 got %h exp %h", obs6(), e);
      end
      Test = 3'd7;
      for (int i = 1; i <= 3; i++) begin
         sb6.push_back(exp_vec(3, 1'b0));
         cycle();
         e = sb6.pop_front();
         checks++;
         if (obs6() !== e) begin
            errors++;
            $display("FAIL oor_sel7_%0d got %h exp %h", i, obs6(), e);
         end
      end
      mode = 1'b1; dwell = 24'd0;
      for (int i = 1; i <= 4; i++) begin
         sb6.push_back(exp_vec((3 + i) % 6, 1'b1));
         cycle();
         e = sb6.pop_front();
         checks++;
         if (obs6() !== e) begin
            errors++;
            $display("FAIL oor_wrap%0d got %h exp %h", i, obs6(), e);
         end
      end
   endtask

   task automatic test_mode_switch();
      vec_t e;
      int   exp_ch [7] = '{4, 4, 4, 1, 1, 1, 2};
      bit   exp_tk [7] = '{1, 0, 0, 1, 0, 0, 1};
      for (int i = 0; i < 7; i++) begin
         case (i)
            0: begin mode = 1'b0; Test = 3'd4; end
            1: begin mode = 1'b1; dwell = 24'd3; end
            3: begin mode = 1'b0; Test = 3'd1; end
            4: begin mode = 1'b1; dwell = 24'd2; end
            default: ;
         endcase
         sb8.push_back(exp_vec(exp_ch[i], exp_tk[i]));
         cycle();
         e = sb8.pop_front();
         checks++;
         if (obs8() !== e) begin
            errors++;
            $display("FAIL mode_sw%0d got %h exp %h", i, obs8(), e);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_auto_wrap();
      test_dwell0_hold();
      test_en_low();
      test_out_of_range();
      test_mode_switch();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
